// File: rtl/noc_params.sv
// Shared NoC types: flit layout, flit labels, output ports and VC sizing.
package noc_params;

    localparam int NOC_VC_NUM = 2;
    localparam int VC_SIZE    = (NOC_VC_NUM > 1) ? $clog2(NOC_VC_NUM) : 1;
    localparam int DATA_SIZE  = 16;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4
    } port_t;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t            flit_label;
        logic [VC_SIZE-1:0]     vc_id;
        logic [DATA_SIZE-1:0]   data;
    } flit_t;

    // Buffered form: the VC id is implied by which buffer holds the flit
    typedef struct packed {
        flit_label_t            flit_label;
        logic [DATA_SIZE-1:0]   data;
    } flit_novc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VA   = 2'd1,
        SA   = 2'd2
    } vc_state_t;

    function automatic logic is_head(input flit_label_t l);
        return (l == HEAD) || (l == HEADTAIL);
    endfunction

    function automatic logic is_end(input flit_label_t l);
        return (l == TAIL) || (l == HEADTAIL);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Show-ahead FIFO for one virtual channel; head entry visible with no read latency.
module vc_fifo
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 4,
    localparam int CNT_W = $clog2(BUFFER_SIZE + 1),
    localparam int PTR_W = $clog2(BUFFER_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  flit_novc_t       data_i,
    input  logic             write_i,
    input  logic             read_i,
    output flit_novc_t       data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    flit_novc_t       mem_q [BUFFER_SIZE];
    flit_novc_t       mem_d [BUFFER_SIZE];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en, rd_en;

    assign full_o  = (count_q == CNT_W'(BUFFER_SIZE));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    // A write into a full buffer is only possible when a pop frees the slot
    assign rd_en = read_i && !empty_o;
    assign wr_en = write_i && (!full_o || rd_en);

    // Next pointers/count; pointers wrap explicitly so any depth works
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        if (wr_en) begin
            mem_d[wptr_q] = data_i;
            wptr_d = (wptr_q == PTR_W'(BUFFER_SIZE - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (rd_en) begin
            rptr_d = (rptr_q == PTR_W'(BUFFER_SIZE - 1)) ? '0 : rptr_q + 1'b1;
        end
    end

    // Storage array carries no reset; validity is tracked by the count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vc_input_buffer.sv
// Router input port: per-VC flit buffers with an IDLE/VA/SA packet state machine each.
module vc_input_buffer
    import noc_params::*;
#(
    parameter int VC_NUM      = NOC_VC_NUM,
    parameter int BUFFER_SIZE = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  flit_t                           data_i,
    input  logic                            write_i,
    input  port_t                           out_port_i,
    input  logic                            read_i,
    input  logic [VC_SIZE-1:0]              read_vc_i,
    input  logic [VC_NUM-1:0]               vc_valid_i,
    input  logic [VC_NUM-1:0][VC_SIZE-1:0]  vc_new_i,
    output flit_t                           data_o,
    output logic                            credit_o,
    output logic [VC_SIZE-1:0]              credit_vc_o,
    output logic [VC_NUM-1:0]               vc_request_o,
    output logic [VC_NUM-1:0]               switch_request_o,
    output logic [VC_NUM-1:0]               vc_allocatable_o,
    output logic [VC_NUM-1:0]               is_empty_o,
    output logic [VC_NUM-1:0]               error_o,
    output port_t [VC_NUM-1:0]              out_port_o,
    output logic [VC_NUM-1:0][VC_SIZE-1:0]  downstream_vc_o
);

    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

    flit_novc_t              head_flit [VC_NUM];
    logic [VC_NUM-1:0]       pop;
    flit_novc_t              wr_flit;
    logic                    credit_q, credit_d;
    logic [VC_SIZE-1:0]      credit_vc_q, credit_vc_d;

    assign wr_flit = '{flit_label: data_i.flit_label, data: data_i.data};

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        vc_state_t          state_q, state_d;
        logic               end_q, end_d;
        logic               alloc_q, alloc_d;
        logic               err_q, err_d;
        port_t              port_q, port_d;
        logic [VC_SIZE-1:0] dvc_q, dvc_d;
        logic               wr_sel, rd_sel, wr_ok, fifo_wr;
        logic               full, empty;
        logic [CNT_W-1:0]   count;

        assign wr_sel  = write_i && (data_i.vc_id == VC_SIZE'(v));
        assign rd_sel  = read_i && (read_vc_i == VC_SIZE'(v));
        assign pop[v]  = rd_sel && (state_q == SA) && !empty;
        assign fifo_wr = wr_sel && wr_ok;

        // Write legality: heads open a packet on an empty idle VC, the rest
        // extend an open packet and may take a slot freed by a same-cycle pop
        always_comb begin
            wr_ok = 1'b0;
            if (is_head(data_i.flit_label))
                wr_ok = (state_q == IDLE) && (count == '0);
            else
                wr_ok = ((state_q == VA) || (state_q == SA)) && !end_q && (!full || pop[v]);
        end

        vc_fifo #(.BUFFER_SIZE(BUFFER_SIZE)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .data_i  (wr_flit),
            .write_i (fifo_wr),
            .read_i  (pop[v]),
            .data_o  (head_flit[v]),
            .count_o (count),
            .full_o  (full),
            .empty_o (empty)
        );

        // Packet FSM: next state, latched route/VC, and one-cycle status pulses
        always_comb begin
            state_d = state_q;
            end_d   = end_q;
            port_d  = port_q;
            dvc_d   = dvc_q;
            alloc_d = 1'b0;
            err_d   = (wr_sel && !wr_ok) || (rd_sel && !pop[v]) ||
                      (vc_valid_i[v] && (state_q != VA));
            if (fifo_wr && is_end(data_i.flit_label))
                end_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (fifo_wr) begin
                        state_d = VA;
                        port_d  = out_port_i;
                    end
                end
                VA: begin
                    if (vc_valid_i[v]) begin
                        state_d = SA;
                        dvc_d   = vc_new_i[v];
                    end
                end
                SA: begin
                    if (pop[v] && is_end(head_flit[v].flit_label)) begin
                        state_d = IDLE;
                        end_d   = 1'b0;
                        alloc_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    end_d   = 1'b0;
                    alloc_d = 1'b1;
                    err_d   = 1'b1;
                end
            endcase
        end

        // Per-VC state registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                end_q   <= 1'b0;
                alloc_q <= 1'b0;
                err_q   <= 1'b0;
                port_q  <= LOCAL;
                dvc_q   <= '0;
            end else begin
                state_q <= state_d;
                end_q   <= end_d;
                alloc_q <= alloc_d;
                err_q   <= err_d;
                port_q  <= port_d;
                dvc_q   <= dvc_d;
            end
        end

        assign vc_request_o[v]     = (state_q == VA);
        assign switch_request_o[v] = (state_q == SA) && !empty;
        assign vc_allocatable_o[v] = alloc_q;
        assign is_empty_o[v]       = empty;
        assign error_o[v]          = err_q;
        assign out_port_o[v]       = port_q;
        assign downstream_vc_o[v]  = dvc_q;
    end

    // Output head of the selected VC, relabelled with its downstream VC
    always_comb begin
        data_o = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            if (read_vc_i == VC_SIZE'(i)) begin
                data_o.flit_label = head_flit[i].flit_label;
                data_o.data       = head_flit[i].data;
                data_o.vc_id      = downstream_vc_o[i];
            end
        end
    end

    // At most one pop per cycle, so one credit register suffices
    always_comb begin
        credit_d    = |pop;
        credit_vc_d = read_vc_i;
    end

    // Credit return register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q    <= 1'b0;
            credit_vc_q <= '0;
        end else begin
            credit_q    <= credit_d;
            credit_vc_q <= credit_vc_d;
        end
    end

    assign credit_o    = credit_q;
    assign credit_vc_o = credit_vc_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench for vc_input_buffer: directed scenarios then random traffic vs a queue model.
module tb_vc_input_buffer;
    import noc_params::*;

    localparam int VCN = NOC_VC_NUM;
    localparam int BS  = 4;
    localparam int M_IDLE = 0, M_VA = 1, M_SA = 2;

    logic                         clk = 1'b0;
    logic                         rst_n;
    flit_t                        data_i;
    logic                         write_i;
    port_t                        out_port_i;
    logic                         read_i;
    logic [VC_SIZE-1:0]           read_vc_i;
    logic [VCN-1:0]               vc_valid_i;
    logic [VCN-1:0][VC_SIZE-1:0]  vc_new_i;
    flit_t                        data_o;
    logic                         credit_o;
    logic [VC_SIZE-1:0]           credit_vc_o;
    logic [VCN-1:0]               vc_request_o, switch_request_o, vc_allocatable_o;
    logic [VCN-1:0]               is_empty_o, error_o;
    port_t [VCN-1:0]              out_port_o;
    logic [VCN-1:0][VC_SIZE-1:0]  downstream_vc_o;

    int total = 0;
    int bad   = 0;

    // Reference model: one queue per VC plus packet-level bookkeeping
    flit_novc_t         mq [VCN][$];
    int                 mst  [VCN];
    bit                 mend [VCN];
    port_t              mport[VCN];
    logic [VC_SIZE-1:0] mdvc [VCN];
    bit                 e_alloc[VCN], e_err[VCN];
    bit                 e_credit;
    logic [VC_SIZE-1:0] e_cvc;

    always #5 clk = ~clk;

    vc_input_buffer #(.VC_NUM(VCN), .BUFFER_SIZE(BS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_i           (data_i),
        .write_i          (write_i),
        .out_port_i       (out_port_i),
        .read_i           (read_i),
        .read_vc_i        (read_vc_i),
        .vc_valid_i       (vc_valid_i),
        .vc_new_i         (vc_new_i),
        .data_o           (data_o),
        .credit_o         (credit_o),
        .credit_vc_o      (credit_vc_o),
        .vc_request_o     (vc_request_o),
        .switch_request_o (switch_request_o),
        .vc_allocatable_o (vc_allocatable_o),
        .is_empty_o       (is_empty_o),
        .error_o          (error_o),
        .out_port_o       (out_port_o),
        .downstream_vc_o  (downstream_vc_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < VCN; v++) begin
            mq[v].delete();
            mst[v] = M_IDLE; mend[v] = 0; mport[v] = LOCAL; mdvc[v] = '0;
            e_alloc[v] = 0; e_err[v] = 0;
        end
        e_credit = 0; e_cvc = '0;
    endtask

    // Apply the packet rules to the inputs currently driven
    task automatic model_step();
        e_credit = 0;
        for (int v = 0; v < VCN; v++) begin
            bit wr, rd, p, ok, hd, en;
            int sz, st0;
            flit_novc_t f;
            wr  = write_i && (int'(data_i.vc_id) == v);
            rd  = read_i && (int'(read_vc_i) == v);
            sz  = mq[v].size();
            st0 = mst[v];
            p   = rd && (st0 == M_SA) && (sz > 0);
            hd  = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);
            en  = (data_i.flit_label == TAIL) || (data_i.flit_label == HEADTAIL);
            if (hd) ok = (st0 == M_IDLE) && (sz == 0);
            else    ok = (st0 != M_IDLE) && !mend[v] && ((sz < BS) || p);
            e_err[v]   = (wr && !ok) || (rd && !p) || (vc_valid_i[v] && (st0 != M_VA));
            e_alloc[v] = 0;
            if (p) begin
                f = mq[v].pop_front();
                e_credit = 1; e_cvc = VC_SIZE'(v);
            end
            if (wr && ok) begin
                mq[v].push_back('{flit_label: data_i.flit_label, data: data_i.data});
                if (hd) begin mst[v] = M_VA; mport[v] = out_port_i; end
                if (en) mend[v] = 1;
            end
            if (st0 == M_VA && vc_valid_i[v]) begin
                mst[v] = M_SA; mdvc[v] = vc_new_i[v];
            end
            if (p && ((f.flit_label == TAIL) || (f.flit_label == HEADTAIL))) begin
                mst[v] = M_IDLE; mend[v] = 0; e_alloc[v] = 1;
            end
        end
    endtask

    task automatic check_data();
        int rv;
        flit_t e;
        rv = int'(read_vc_i);
        if (mq[rv].size() > 0) begin
            e.flit_label = mq[rv][0].flit_label;
            e.vc_id      = mdvc[rv];
            e.data       = mq[rv][0].data;
            chk("data_o", data_o, e);
        end
    endtask

    task automatic check_outputs();
        chk("credit", credit_o, e_credit);
        if (e_credit) chk("credit_vc", credit_vc_o, e_cvc);
        for (int v = 0; v < VCN; v++) begin
            chk($sformatf("empty%0d", v),  is_empty_o[v], mq[v].size() == 0);
            chk($sformatf("vcreq%0d", v),  vc_request_o[v], mst[v] == M_VA);
            chk($sformatf("swreq%0d", v),  switch_request_o[v], (mst[v] == M_SA) && (mq[v].size() > 0));
            chk($sformatf("alloc%0d", v),  vc_allocatable_o[v], e_alloc[v]);
            chk($sformatf("err%0d", v),    error_o[v], e_err[v]);
            chk($sformatf("port%0d", v),   out_port_o[v], mport[v]);
            chk($sformatf("dvc%0d", v),    downstream_vc_o[v], mdvc[v]);
        end
    endtask

    // Called just after a falling edge with inputs already applied
    task automatic cycle();
        #1;
        check_data();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_in(input bit wr, input flit_label_t lbl, input int wv, input logic [15:0] d,
                          input port_t p, input bit rd, input int rv,
                          input logic [VCN-1:0] vv, input logic [VCN-1:0][VC_SIZE-1:0] vn);
        write_i = wr;
        data_i.flit_label = lbl;
        data_i.vc_id = VC_SIZE'(wv);
        data_i.data = d;
        out_port_i = p;
        read_i = rd;
        read_vc_i = VC_SIZE'(rv);
        vc_valid_i = vv;
        vc_new_i = vn;
    endtask

    task automatic drive(input bit wr, input flit_label_t lbl, input int wv, input logic [15:0] d,
                         input port_t p, input bit rd, input int rv,
                         input logic [VCN-1:0] vv, input logic [VCN-1:0][VC_SIZE-1:0] vn);
        set_in(wr, lbl, wv, d, p, rd, rv, vv, vn);
        cycle();
    endtask

    task automatic idle();
        drive(0, BODY, 0, 16'h0, LOCAL, 0, 0, '0, '0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_credit"}, credit_o, 0);
        chk({tag, "_empty"},  is_empty_o, {VCN{1'b1}});
        chk({tag, "_err"},    error_o, 0);
        chk({tag, "_alloc"},  vc_allocatable_o, 0);
        chk({tag, "_vcreq"},  vc_request_o, 0);
        chk({tag, "_swreq"},  switch_request_o, 0);
        chk({tag, "_port"},   out_port_o, {VCN{LOCAL}});
        chk({tag, "_dvc"},    downstream_vc_o, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, BODY, 0, 16'h0, LOCAL, 0, 0, '0, '0);
        model_reset();
        #3;
        check_reset_vals("rst0");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Single-flit packet on VC0: route, VC grant, pop, credit, release
        drive(1, HEADTAIL, 0, 16'h00A5, EAST, 0, 0, '0, '0);
        chk("r037_port", out_port_o[0], EAST);
        chk("r037_vcreq", vc_request_o[0], 1);
        drive(0, BODY, 0, 16'h0, LOCAL, 0, 0, 2'b01, {1'b0, 1'b1});
        set_in(0, BODY, 0, 16'h0, LOCAL, 1, 0, '0, '0);
        #1;
        chk("r037_vcid", data_o.vc_id, 1);
        cycle();
        chk("r037_credit", credit_o, 1);
        chk("r037_cvc", credit_vc_o, 0);
        chk("r037_alloc", vc_allocatable_o[0], 1);
        idle();
        chk("r037_alloc_off", vc_allocatable_o[0], 0);
        chk("r037_idle", vc_request_o[0] | switch_request_o[0], 0);

        // Fill VC1, overflow, then write-while-pop on a full VC
        drive(1, HEAD, 1, 16'h0300, NORTH, 0, 0, '0, '0);
        chk("r038_nonempty", is_empty_o[1], 0);
        drive(1, BODY, 1, 16'h0301, LOCAL, 0, 0, '0, '0);
        drive(1, BODY, 1, 16'h0302, LOCAL, 0, 0, '0, '0);
        drive(1, BODY, 1, 16'h0303, LOCAL, 0, 0, '0, '0);
        drive(1, BODY, 1, 16'h03FF, LOCAL, 0, 0, '0, '0);
        chk("r038_ovf_err", error_o[1], 1);
        drive(0, BODY, 0, 16'h0, LOCAL, 0, 0, 2'b10, {1'b0, 1'b0});
        drive(1, BODY, 1, 16'h0304, LOCAL, 1, 1, '0, '0);
        chk("r039_credit", credit_o, 1);
        chk("r039_no_err", error_o[1], 0);
        drive(1, BODY, 1, 16'h03EE, LOCAL, 0, 0, '0, '0);
        chk("r039_still_full", error_o[1], 1);
        drive(1, TAIL, 1, 16'h0305, LOCAL, 1, 1, '0, '0);
        for (int i = 0; i < 4; i++) drive(0, BODY, 0, 16'h0, LOCAL, 1, 1, '0, '0);
        chk("r039_alloc", vc_allocatable_o[1], 1);

        // Interleaved traffic on both VCs with alternating pops
        drive(1, HEAD, 0, 16'h0100, WEST, 0, 0, '0, '0);
        drive(1, HEAD, 1, 16'h0200, SOUTH, 0, 0, '0, '0);
        drive(0, BODY, 0, 16'h0, LOCAL, 0, 0, 2'b11, {1'b0, 1'b1});
        for (int i = 0; i < 8; i++)
            drive(1, (i >= 6) ? TAIL : BODY, i % 2, 16'(16'h0110 + i), LOCAL, 1, (i + 1) % 2, '0, '0);
        for (int i = 0; i < 4; i++) drive(0, BODY, 0, 16'h0, LOCAL, 1, i % 2, '0, '0);

        // Reset with VC0 mid-packet in SA holding three flits
        drive(1, HEAD, 0, 16'h0400, EAST, 0, 0, '0, '0);
        drive(1, BODY, 0, 16'h0401, LOCAL, 0, 0, '0, '0);
        drive(1, BODY, 0, 16'h0402, LOCAL, 0, 0, 2'b01, {1'b0, 1'b1});
        chk("r041_sa", switch_request_o[0], 1);
        set_in(0, BODY, 0, 16'h0, LOCAL, 1, 0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("r041a");
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("r041b");
        set_in(0, BODY, 0, 16'h0, LOCAL, 0, 0, '0, '0);
        rst_n = 1'b1;
        model_reset();
        drive(1, HEAD, 0, 16'h0500, NORTH, 0, 0, '0, '0);
        chk("r041_head_ok", vc_request_o[0], 1);
        chk("r041_head_err", error_o[0], 0);

        // Random traffic biased toward legal packet sequences
        for (int n = 0; n < 2000; n++) begin
            int v;
            flit_label_t lbl;
            logic [VCN-1:0] vv;
            logic [VCN-1:0][VC_SIZE-1:0] vn;
            v = $urandom_range(0, VCN - 1);
            if (mst[v] == M_IDLE && mq[v].size() == 0)
                lbl = ($urandom_range(0, 1) != 0) ? HEAD : HEADTAIL;
            else
                lbl = ($urandom_range(0, 99) < 70) ? BODY : TAIL;
            if ($urandom_range(0, 99) < 10) lbl = flit_label_t'($urandom_range(0, 3));
            for (int k = 0; k < VCN; k++) begin
                vv[k] = (mst[k] == M_VA) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 99) < 3);
                vn[k] = VC_SIZE'($urandom_range(0, VCN - 1));
            end
            drive($urandom_range(0, 99) < 70, lbl, v, 16'($urandom),
                  port_t'($urandom_range(0, 4)),
                  $urandom_range(0, 99) < 60, $urandom_range(0, VCN - 1), vv, vn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
